seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Transmit-side companion to the serial "10101" sequence detector.
- Serializes a fixed bit pattern MSB-first onto a one-bit line, repeated a programmable number of bursts with idle gaps between them.
- Used to drive detector inputs on-chip and as a stimulus source on the tile's IO.
- Registered outputs only; one clock domain.

Parameters:
- PAT_LEN, 5, pattern length in bits (2..16).
- PATTERN, 5'b10101, pattern transmitted MSB (bit PAT_LEN-1) first.
- GAP_LEN, 2, idle cycles between bursts (0..15; 0 = back-to-back bursts).
- IDLE_LEVEL, 1'b0, line level driven whenever no pattern bit is valid.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ena  input  1  clock enable; when 0 every register holds.
- start  input  1  begin a transmission; sampled only in IDLE with ena=1.
- abort  input  1  cancel the transmission in progress.
- repeat_cnt  input  4  number of extra bursts (0 = 1 burst, 15 = 16 bursts); latched at start.
- output_bit  output  1  serial data line.
- bit_valid  output  1  1 while output_bit carries a pattern bit.
- busy  output  1  1 in any state other than IDLE.
- done  output  1  one-cycle pulse after the final burst completes.
- present_state  output  3  current FSM state code, for debug and observation.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE (000).
  - output_bit = IDLE_LEVEL; bit_valid, busy and done = 0.
  - Bit index and burst counter cleared.
  - Release is synchronous to clk.
- ena=0: state, counters and all outputs hold their values. done stays high if it was high; the pulse extends until the next ena=1 edge.
- State codes: IDLE=000, SEND=001, GAP=010, DONE=011.
- IDLE:
  - start=1 at edge N moves the FSM to SEND.
  - repeat_cnt is latched into the burst counter.
  - The bit index is set to PAT_LEN-1.
  - From edge N, output_bit = PATTERN[PAT_LEN-1] and bit_valid = 1. Latency from start to the first bit is 1 cycle.
- SEND:
  - Each enabled edge decrements the bit index and drives PATTERN[index] with bit_valid=1.
  - A burst occupies exactly PAT_LEN consecutive enabled cycles.
- After the last bit (index 0):
  - Burst counter = 0 → DONE.
  - Burst counter > 0 and GAP_LEN > 0 → GAP; counter decrements.
  - Burst counter > 0 and GAP_LEN = 0 → SEND directly with index reset to PAT_LEN-1; counter decrements. No idle cycle between bursts.
- GAP: output_bit = IDLE_LEVEL and bit_valid = 0 for exactly GAP_LEN enabled cycles, then SEND with index PAT_LEN-1.
- DONE:
  - Lasts one enabled cycle with done=1, busy=1, bit_valid=0, output_bit=IDLE_LEVEL.
  - Then returns to IDLE with done=0.
- start outside IDLE is ignored. start in the DONE cycle is also ignored; it must be re-asserted in IDLE.
- abort=1 with ena=1 in any non-IDLE state:
  - FSM goes to IDLE at the next edge.
  - bit_valid=0, output_bit=IDLE_LEVEL, no done pulse.
  - abort has priority over every other transition.
  - abort in IDLE has no effect; abort and start together in IDLE → start is ignored.
- Total bits for one transmission: (repeat_cnt+1)*PAT_LEN pattern bits plus repeat_cnt*GAP_LEN idle cycles.

Optional Feature:
- Macro: SEQGEN_PARITY_EN.
- Defined:
  - A PARITY state (100) follows every burst's last bit.
  - PARITY drives one extra bit with bit_valid=1: the odd-parity bit of PATTERN (XOR of all PATTERN bits, inverted).
  - Gap/done sequencing then proceeds from PARITY exactly as it would from the last bit.
  - Each burst becomes PAT_LEN+1 cycles; abort and ena rules apply unchanged.
- Undefined: no PARITY state; code 100 is never produced.

Test Plan:
- Reset then start (repeat_cnt=0, defaults) → output_bit 1,0,1,0,1 on 5 consecutive cycles with bit_valid=1, then done=1 for 1 cycle, then busy=0.
- repeat_cnt=2, GAP_LEN=2 → 3 bursts of 10101, each separated by 2 cycles of bit_valid=0 and output_bit=0. done pulses once after cycle 19. Feeding output_bit to the detector yields 3 detections.
- GAP_LEN=0, repeat_cnt=1 → 10 consecutive valid bits 1010110101, no idle cycle between bursts.
- Toggle ena=0 for 3 cycles in the middle of burst 1 → output_bit and state frozen; the sequence resumes unchanged, and the total valid-bit count is still 5 per burst.
- abort on the 3rd bit, with start held high throughout → IDLE next cycle, no done. Re-assert start in IDLE → a fresh 10101 from bit 4.
- reset asserted low in the middle of GAP → outputs go to reset values immediately (asynchronously). After release, start produces a normal burst. With SEQGEN_PARITY_EN defined, each burst ends with parity bit 0 (PATTERN 10101 has odd weight).

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts PATTERN out MSB-first in (repeat_cnt+1) bursts separated by GAP_LEN idle cycles.
// Optional macro SEQGEN_PARITY_EN appends an odd-parity bit (PARITY state, code 100) after every burst.
module seq_pattern_gen #(
  parameter int                 PAT_LEN    = 5,
  parameter logic [PAT_LEN-1:0] PATTERN    = 5'b10101,
  parameter int                 GAP_LEN    = 2,
  parameter logic               IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] repeat_cnt,
  output logic       output_bit,
  output logic       bit_valid,
  output logic       busy,
  output logic       done,
  output logic [2:0] present_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SEND   = 3'b001,
    GAP    = 3'b010,
    DONE   = 3'b011,
    PARITY = 3'b100
  } state_t;

  // Pattern is zero-extended to 16 bits so a 4-bit index always selects exactly.
  localparam logic [15:0] PAT_EXT  = 16'(PATTERN);
  localparam logic [3:0]  LAST_IDX = 4'(PAT_LEN - 1);
  localparam logic [3:0]  GAP_LOAD = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;
`ifdef SEQGEN_PARITY_EN
  localparam logic        PARITY_BIT = ~(^PATTERN);
`endif

  state_t     state, state_nxt;
  logic [3:0] bit_idx, idx_nxt;
  logic [3:0] burst_cnt, burst_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic       bit_q, bit_nxt;
  logic       valid_q, valid_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;
  logic       burst_end;

  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    burst_nxt = burst_cnt;
    gap_nxt   = gap_cnt;
    bit_nxt   = IDLE_LEVEL;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    burst_end = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SEND;
          idx_nxt   = LAST_IDX;
          burst_nxt = repeat_cnt;
          bit_nxt   = PAT_EXT[LAST_IDX];
          valid_nxt = 1'b1;
        end
      end
      SEND: begin
        if (bit_idx != 4'd0) begin
          idx_nxt   = bit_idx - 4'd1;
          bit_nxt   = PAT_EXT[idx_nxt];
          valid_nxt = 1'b1;
        end else begin
`ifdef SEQGEN_PARITY_EN
          state_nxt = PARITY;
          bit_nxt   = PARITY_BIT;
          valid_nxt = 1'b1;
`else
          burst_end = 1'b1;
`endif
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          state_nxt = SEND;
          idx_nxt   = LAST_IDX;
          bit_nxt   = PAT_EXT[LAST_IDX];
          valid_nxt = 1'b1;
        end else begin
          gap_nxt = gap_cnt - 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
`ifdef SEQGEN_PARITY_EN
      PARITY: begin
        burst_end = 1'b1;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The final cycle of a burst decides between finishing, idling, or restarting.
    if (burst_end) begin
      if (burst_cnt == 4'd0) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end else if (GAP_LEN > 0) begin
        state_nxt = GAP;
        gap_nxt   = GAP_LOAD;
        burst_nxt = burst_cnt - 4'd1;
      end else begin
        state_nxt = SEND;
        idx_nxt   = LAST_IDX;
        bit_nxt   = PAT_EXT[LAST_IDX];
        valid_nxt = 1'b1;
        burst_nxt = burst_cnt - 4'd1;
      end
    end

    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      bit_nxt   = IDLE_LEVEL;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_idx   <= 4'd0;
      burst_cnt <= 4'd0;
      gap_cnt   <= 4'd0;
      bit_q     <= IDLE_LEVEL;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (ena) begin
      state     <= state_nxt;
      bit_idx   <= idx_nxt;
      burst_cnt <= burst_nxt;
      gap_cnt   <= gap_nxt;
      bit_q     <= bit_nxt;
      valid_q   <= valid_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign output_bit    = bit_q;
  assign bit_valid     = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign present_state = state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: a cycle-level expected stream is queued per transmission and a monitor compares every enabled cycle.
`timescale 1ns/1ps
module tb_seq_pattern_gen;

  localparam int         PAT_LEN    = 5;
  localparam logic [4:0] PAT        = 5'b10101;
  localparam int         GAP_LEN    = 2;
  localparam logic       IDLE_LEVEL = 1'b0;

  typedef struct packed {
    logic       bitv;
    logic       valid;
    logic       dn;
    logic       bsy;
    logic [2:0] st;
  } ent_t;

  localparam ent_t IDLE_ENT = '0;

  logic       clk;
  logic       reset;
  logic       ena;
  logic       start;
  logic       abort;
  logic [3:0] repeat_cnt;
  logic       output_bit;
  logic       bit_valid;
  logic       busy;
  logic       done;
  logic [2:0] present_state;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  ent_t model_q[$];
  ent_t last_exp = '0;

  seq_pattern_gen #(
    .PAT_LEN(PAT_LEN),
    .PATTERN(PAT),
    .GAP_LEN(GAP_LEN),
    .IDLE_LEVEL(IDLE_LEVEL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ena(ena),
    .start(start),
    .abort(abort),
    .repeat_cnt(repeat_cnt),
    .output_bit(output_bit),
    .bit_valid(bit_valid),
    .busy(busy),
    .done(done),
    .present_state(present_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t mk(input logic b, input logic v, input logic d, input logic bz, input logic [2:0] s);
    return ent_t'({b, v, d, bz, s});
  endfunction

  task automatic check_ent(input string nm, input ent_t e);
    ent_t act;
    act = ent_t'({output_bit, bit_valid, done, busy, present_state});
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got bit=%b valid=%b done=%b busy=%b state=%0d, expected bit=%b valid=%b done=%b busy=%b state=%0d",
               nm, $time, act.bitv, act.valid, act.dn, act.bsy, act.st, e.bitv, e.valid, e.dn, e.bsy, e.st);
    end
  endtask

  // Reference: one entry per enabled cycle from the start edge through the done cycle.
  task automatic build_stream(input int rep);
`ifdef SEQGEN_PARITY_EN
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < PAT_LEN; i++) ones += int'(PAT[3'(i)]);
    par = (ones % 2 == 0);
`endif
    model_q.delete();
    for (int b = 0; b <= rep; b++) begin
      for (int i = PAT_LEN - 1; i >= 0; i--)
        model_q.push_back(mk(PAT[3'(i)], 1'b1, 1'b0, 1'b1, 3'd1));
`ifdef SEQGEN_PARITY_EN
      model_q.push_back(mk(par, 1'b1, 1'b0, 1'b1, 3'd4));
`endif
      if (b < rep)
        for (int g = 0; g < GAP_LEN; g++)
          model_q.push_back(mk(IDLE_LEVEL, 1'b0, 1'b0, 1'b1, 3'd2));
    end
    model_q.push_back(mk(IDLE_LEVEL, 1'b0, 1'b1, 1'b1, 3'd3));
  endtask

  // abort_pos >= 0 aborts while that stream entry is on the line; hole_pct sets ena=0 frequency.
  task automatic applyStimulus(input int rep, input int abort_pos, input int hole_pct);
    int total, need, edges, holes, apos;
    build_stream(rep);
    total = model_q.size();
    apos  = (abort_pos >= total) ? -1 : abort_pos;
    @(negedge clk);
    repeat_cnt = 4'(rep);
    start = 1'b1;
    abort = 1'b0;
    ena   = 1'b1;
    for (int i = 0; i < total; i++)
      if (apos < 0 || i <= apos) exp_q.push_back(model_q[i]);
    need  = (apos >= 0) ? apos + 1 : total;
    edges = 0;
    holes = 0;
    while (edges < need) begin
      @(negedge clk);
      start      = (apos >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
      repeat_cnt = 4'($urandom_range(0, 15));
      if (holes < 40 && $urandom_range(0, 99) < hole_pct) begin
        ena   = 1'b0;
        abort = 1'($urandom_range(0, 1));
        holes++;
      end else begin
        ena = 1'b1;
        edges++;
        abort = (apos >= 0 && edges == need);
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    ena   = 1'b1;
  endtask

  task automatic resetInGap();
    int gpos;
`ifdef SEQGEN_PARITY_EN
    gpos = PAT_LEN + 1;
`else
    gpos = PAT_LEN;
`endif
    build_stream(1);
    @(negedge clk);
    repeat_cnt = 4'd1;
    start = 1'b1;
    abort = 1'b0;
    ena   = 1'b1;
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    @(negedge clk);
    start = 1'b0;
    repeat (gpos) @(negedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_ent("async_reset_in_gap", IDLE_ENT);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every enabled edge pops the next expected entry, otherwise expects idle or held outputs.
  always @(posedge clk) begin
    logic en_s;
    ent_t e;
    en_s = ena;
    #1;
    if (!reset) begin
      last_exp = IDLE_ENT;
    end else if (!en_s) begin
      check_ent("hold", last_exp);
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_ent("stream", e);
      last_exp = e;
    end else begin
      check_ent("idle", IDLE_ENT);
      last_exp = IDLE_ENT;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_expected: got %0d pending entries, expected 0", exp_q.size());
    end
  endtask

  initial begin
    int rep, apos, total, blen;
    reset      = 1'b0;
    ena        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    repeat_cnt = 4'd0;
    #3;
    check_ent("reset_state", IDLE_ENT);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(0, -1, 0);
    applyStimulus(2, -1, 0);
    applyStimulus(0, -1, 40);
    applyStimulus(1, 2, 0);
    applyStimulus(0, -1, 0);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    resetInGap();
    applyStimulus(0, -1, 0);

`ifdef SEQGEN_PARITY_EN
    blen = PAT_LEN + 1;
`else
    blen = PAT_LEN;
`endif
    for (int n = 0; n < 30; n++) begin
      rep   = $urandom_range(0, 5);
      total = (rep + 1) * blen + rep * GAP_LEN + 1;
      apos  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
      applyStimulus(rep, apos, $urandom_range(0, 30));
    end
    applyStimulus(15, -1, 10);

    repeat (3) @(negedge clk);
    checkOutput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
